// File: rtl/mem_bist_pkg.sv
// Shared types and March C- element tables for the SRAM BIST controller.
package mem_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [2:0] elem_t;

  localparam elem_t E0 = 3'd0;
  localparam elem_t E1 = 3'd1;
  localparam elem_t E2 = 3'd2;
  localparam elem_t E3 = 3'd3;
  localparam elem_t E4 = 3'd4;
  localparam elem_t E5 = 3'd5;

  // Operations issued per address: E0 is write-only, E5 read-only, the rest read then write.
  function automatic logic [1:0] elem_ops(elem_t e);
    return ((e == E0) || (e == E5)) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic elem_down(elem_t e);
    return (e == E3) || (e == E4);
  endfunction

  // 1 selects the inverted background ~BG0, 0 selects BG0.
  function automatic logic elem_rpat(elem_t e);
    return (e == E2) || (e == E4);
  endfunction

  function automatic logic elem_wpat(elem_t e);
    return (e == E1) || (e == E3);
  endfunction

endpackage

// File: rtl/mem_bist_addr_gen.sv
// Up/down SRAM address counter; load picks the start address for the direction.
module mem_bist_addr_gen #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              load_down,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              at_last
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic down;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
      down <= 1'b0;
    end else if (load) begin
      down <= load_down;
      addr <= load_down ? '1 : '0;
    end else if (step) begin
      addr <= down ? (addr - ONE) : (addr + ONE);
    end
  end

  assign at_last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/mem_bist_controller.sv
// March C- BIST initiator: drives a single-port SRAM one op per cycle, captures first mismatch.
module mem_bist_controller
  import mem_bist_pkg::*;
#(
  parameter int                ADDR_W = 11,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] BG0    = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] fail_exp,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state, state_nxt;
  elem_t             elem;
  logic              phase;
  logic [DATA_W-1:0] exp_data, wr_data;
  logic              cur_read, mismatch, last_op, run_end, start_run, advance;
  logic              at_last, load, load_down, step;

  // elem/phase/mem_addr always describe the operation currently on the mem_* outputs.
  assign exp_data  = elem_rpat(elem) ? ~BG0 : BG0;
  assign wr_data   = elem_wpat(elem) ? ~BG0 : BG0;
  assign cur_read  = (elem != E0) && !phase;
  assign mismatch  = (state == ST_RUN) && cur_read && (mem_rdata != exp_data);
  assign last_op   = (elem_ops(elem) == 2'd1) || phase;
  assign run_end   = (state == ST_RUN) && last_op && at_last && (elem == E5);
  assign start_run = (state != ST_RUN) && start;
  assign advance   = (state == ST_RUN) && !mismatch && last_op;
  assign step      = advance && !at_last;
  assign load      = start_run || (advance && at_last && (elem != E5));
  assign load_down = start_run ? 1'b0 : elem_down(elem_t'(elem + 3'd1));

  mem_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_down(load_down),
    .step     (step),
    .addr     (mem_addr),
    .at_last  (at_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (mismatch || run_end) state_nxt = ST_DONE;
      ST_DONE: if (start) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      elem      <= E0;
      phase     <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_exp  <= '0;
    end else if (start_run) begin
      elem      <= E0;
      phase     <= 1'b0;
      mem_we    <= 1'b1;
      mem_wdata <= BG0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_exp  <= '0;
    end else if (state == ST_RUN) begin
      if (mismatch) begin
        fail      <= 1'b1;
        fail_addr <= mem_addr;
        fail_data <= mem_rdata;
        fail_exp  <= exp_data;
        mem_we    <= 1'b0;
      end else if (run_end) begin
        pass   <= 1'b1;
        mem_we <= 1'b0;
      end else if (!last_op) begin
        phase     <= 1'b1;
        mem_we    <= 1'b1;
        mem_wdata <= wr_data;
      end else if (!at_last) begin
        phase     <= 1'b0;
        mem_we    <= (elem == E0);
        mem_wdata <= wr_data;
      end else begin
        // Every element after E0 opens with a read at its start address.
        elem   <= elem_t'(elem + 3'd1);
        phase  <= 1'b0;
        mem_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bist_controller.sv
// Directed bench: default-size DUT with a fault-injectable SRAM model, plus an 8-word DUT for trace checks.
module tb_mem_bist_controller;

  localparam int LIMIT = 25000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  int          total = 0;
  int          bad = 0;
  int          fault_mode;

  logic        busy_a, done_a, pass_a, fail_a, we_a;
  logic [10:0] fail_addr_a, addr_a;
  logic [7:0]  fail_data_a, fail_exp_a, wdata_a, rdata_a;
  logic [7:0]  mem_a [2048];

  logic        busy_b, done_b, pass_b, fail_b, we_b;
  logic [2:0]  fail_addr_b, addr_b;
  logic [7:0]  fail_data_b, fail_exp_b, wdata_b, rdata_b;
  logic [7:0]  mem_b [8];

  logic [2:0]  exp_addr [80];
  logic        exp_we   [80];
  logic [7:0]  exp_wd   [80];

  always #5 clk = ~clk;

  mem_bist_controller dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .fail(fail_a), .fail_addr(fail_addr_a), .fail_data(fail_data_a),
    .fail_exp(fail_exp_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .mem_rdata(rdata_a)
  );

  mem_bist_controller #(.ADDR_W(3), .DATA_W(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .fail(fail_b), .fail_addr(fail_addr_b), .fail_data(fail_data_b),
    .fail_exp(fail_exp_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .mem_rdata(rdata_b)
  );

  // Mode 1: bit 3 stuck at 1 on address 100. Mode 2: writing FF to address 5 also sets address 6.
  always_comb rdata_a = mem_a[addr_a] | (((fault_mode == 1) && (addr_a == 11'd100)) ? 8'h08 : 8'h00);

  always @(posedge clk) begin
    if (we_a) begin
      mem_a[addr_a] <= wdata_a;
      if ((fault_mode == 2) && (addr_a == 11'd5) && (wdata_a == 8'hFF)) mem_a[6] <= 8'hFF;
    end
  end

  always_comb rdata_b = mem_b[addr_b];

  always @(posedge clk) begin
    if (we_b) mem_b[addr_b] <= wdata_b;
  end

  task automatic launch_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic count_run_a(output int cyc, output int wr);
    cyc = 0;
    wr  = 0;
    while (busy_a && (cyc < LIMIT)) begin
      cyc++;
      if (we_a) wr++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0h want 0", busy_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done: got %0h want 0", done_a); end
    total++; if ({pass_a, fail_a} !== 2'b00) begin bad++; $display("FAIL reset_pass_fail: got %0h want 0", {pass_a, fail_a}); end
    total++; if (we_a !== 1'b0) begin bad++; $display("FAIL reset_we: got %0h want 0", we_a); end
    total++; if (addr_a !== 11'd0) begin bad++; $display("FAIL reset_addr: got %0h want 0", addr_a); end
    total++; if (wdata_a !== 8'd0) begin bad++; $display("FAIL reset_wdata: got %0h want 0", wdata_a); end
    total++; if ({fail_addr_a, fail_data_a, fail_exp_a} !== 27'd0) begin bad++; $display("FAIL reset_fail_info: got %0h want 0", {fail_addr_a, fail_data_a, fail_exp_a}); end
    total++; if ({busy_b, done_b, we_b, addr_b} !== 6'd0) begin bad++; $display("FAIL reset_small: got %0h want 0", {busy_b, done_b, we_b, addr_b}); end
    reset = 1'b0;
  endtask

  task automatic test_full_run();
    int cyc, wr, nz;
    repeat (10) @(negedge clk);
    launch_a();
    count_run_a(cyc, wr);
    total++; if (cyc != 20480) begin bad++; $display("FAIL full_busy_cycles: got %0d want 20480", cyc); end
    total++; if (wr != 10240) begin bad++; $display("FAIL full_writes: got %0d want 10240", wr); end
    total++; if ({done_a, pass_a, fail_a} !== 3'b110) begin bad++; $display("FAIL full_status: got %0b want 110", {done_a, pass_a, fail_a}); end
    total++; if (we_a !== 1'b0) begin bad++; $display("FAIL full_we_after: got %0h want 0", we_a); end
    total++; if (addr_a !== 11'd2047) begin bad++; $display("FAIL full_addr_held: got %0h want 7ff", addr_a); end
    nz = 0;
    for (int i = 0; i < 2048; i++) if (mem_a[i] !== 8'h00) nz++;
    total++; if (nz != 0) begin bad++; $display("FAIL full_mem_zero: got %0d nonzero want 0", nz); end
  endtask

  task automatic test_small_trace();
    int idx;
    idx = 0;
    for (int a = 0; a < 8; a++) begin exp_addr[idx] = 3'(a); exp_we[idx] = 1'b1; exp_wd[idx] = 8'h00; idx++; end
    for (int a = 0; a < 8; a++) begin
      exp_addr[idx] = 3'(a); exp_we[idx] = 1'b0; exp_wd[idx] = 8'h00; idx++;
      exp_addr[idx] = 3'(a); exp_we[idx] = 1'b1; exp_wd[idx] = 8'hFF; idx++;
    end
    for (int a = 0; a < 8; a++) begin
      exp_addr[idx] = 3'(a); exp_we[idx] = 1'b0; exp_wd[idx] = 8'h00; idx++;
      exp_addr[idx] = 3'(a); exp_we[idx] = 1'b1; exp_wd[idx] = 8'h00; idx++;
    end
    for (int a = 7; a >= 0; a--) begin
      exp_addr[idx] = 3'(a); exp_we[idx] = 1'b0; exp_wd[idx] = 8'h00; idx++;
      exp_addr[idx] = 3'(a); exp_we[idx] = 1'b1; exp_wd[idx] = 8'hFF; idx++;
    end
    for (int a = 7; a >= 0; a--) begin
      exp_addr[idx] = 3'(a); exp_we[idx] = 1'b0; exp_wd[idx] = 8'h00; idx++;
      exp_addr[idx] = 3'(a); exp_we[idx] = 1'b1; exp_wd[idx] = 8'h00; idx++;
    end
    for (int a = 0; a < 8; a++) begin exp_addr[idx] = 3'(a); exp_we[idx] = 1'b0; exp_wd[idx] = 8'h00; idx++; end

    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 80; i++) begin
      total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL trace_busy[%0d]: got %0h want 1", i, busy_b); end
      total++; if (addr_b !== exp_addr[i]) begin bad++; $display("FAIL trace_addr[%0d]: got %0d want %0d", i, addr_b, exp_addr[i]); end
      total++; if (we_b !== exp_we[i]) begin bad++; $display("FAIL trace_we[%0d]: got %0h want %0h", i, we_b, exp_we[i]); end
      if (exp_we[i]) begin
        total++; if (wdata_b !== exp_wd[i]) begin bad++; $display("FAIL trace_wdata[%0d]: got %0h want %0h", i, wdata_b, exp_wd[i]); end
      end
      @(negedge clk);
    end
    total++; if ({busy_b, done_b, pass_b, fail_b} !== 4'b0110) begin bad++; $display("FAIL trace_end_status: got %0b want 0110", {busy_b, done_b, pass_b, fail_b}); end
  endtask

  task automatic test_stuck_at();
    int cyc, wr;
    fault_mode = 1;
    launch_a();
    total++; if ({done_a, pass_a, fail_a} !== 3'b000) begin bad++; $display("FAIL stuck_status_cleared: got %0b want 000", {done_a, pass_a, fail_a}); end
    count_run_a(cyc, wr);
    total++; if (cyc != 2249) begin bad++; $display("FAIL stuck_busy_cycles: got %0d want 2249", cyc); end
    total++; if (wr != 2148) begin bad++; $display("FAIL stuck_writes: got %0d want 2148", wr); end
    total++; if ({done_a, pass_a, fail_a} !== 3'b101) begin bad++; $display("FAIL stuck_status: got %0b want 101", {done_a, pass_a, fail_a}); end
    total++; if (fail_addr_a !== 11'd100) begin bad++; $display("FAIL stuck_fail_addr: got %0d want 100", fail_addr_a); end
    total++; if (fail_data_a !== 8'h08) begin bad++; $display("FAIL stuck_fail_data: got %0h want 08", fail_data_a); end
    total++; if (fail_exp_a !== 8'h00) begin bad++; $display("FAIL stuck_fail_exp: got %0h want 00", fail_exp_a); end
    wr = 0;
    repeat (6) begin
      if (we_a !== 1'b0) wr++;
      @(negedge clk);
    end
    total++; if (wr != 0) begin bad++; $display("FAIL stuck_writes_after: got %0d want 0", wr); end
    fault_mode = 0;
  endtask

  task automatic test_coupling();
    int cyc, wr;
    fault_mode = 2;
    launch_a();
    count_run_a(cyc, wr);
    total++; if (cyc != 2061) begin bad++; $display("FAIL coup_busy_cycles: got %0d want 2061", cyc); end
    total++; if (wr != 2054) begin bad++; $display("FAIL coup_writes: got %0d want 2054", wr); end
    total++; if ({done_a, pass_a, fail_a} !== 3'b101) begin bad++; $display("FAIL coup_status: got %0b want 101", {done_a, pass_a, fail_a}); end
    total++; if (fail_addr_a !== 11'd6) begin bad++; $display("FAIL coup_fail_addr: got %0d want 6", fail_addr_a); end
    total++; if (fail_data_a !== 8'hFF) begin bad++; $display("FAIL coup_fail_data: got %0h want ff", fail_data_a); end
    total++; if (fail_exp_a !== 8'h00) begin bad++; $display("FAIL coup_fail_exp: got %0h want 00", fail_exp_a); end
    fault_mode = 0;
  endtask

  task automatic test_reset_mid_run();
    int cyc, wr;
    launch_a();
    repeat (500) @(negedge clk);
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %0h want 1", busy_a); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (we_a !== 1'b0) begin bad++; $display("FAIL midrst_we: got %0h want 0", we_a); end
    total++; if ({busy_a, done_a, pass_a, fail_a} !== 4'b0000) begin bad++; $display("FAIL midrst_status: got %0b want 0000", {busy_a, done_a, pass_a, fail_a}); end
    total++; if (addr_a !== 11'd0) begin bad++; $display("FAIL midrst_addr: got %0h want 0", addr_a); end
    launch_a();
    count_run_a(cyc, wr);
    total++; if (cyc != 20480) begin bad++; $display("FAIL midrst_rerun_cycles: got %0d want 20480", cyc); end
    total++; if ({done_a, pass_a, fail_a} !== 3'b110) begin bad++; $display("FAIL midrst_rerun_status: got %0b want 110", {done_a, pass_a, fail_a}); end
  endtask

  task automatic test_start_ignored_and_held();
    int cyc;
    launch_a();
    cyc = 0;
    while (busy_a && (cyc < LIMIT)) begin
      cyc++;
      if (cyc == 1000) start_a = 1'b1;
      else if (cyc == 1001) start_a = 1'b0;
      else if (cyc == 20000) start_a = 1'b1;
      @(negedge clk);
    end
    total++; if (cyc != 20480) begin bad++; $display("FAIL held_first_cycles: got %0d want 20480", cyc); end
    total++; if ({done_a, pass_a, fail_a} !== 3'b110) begin bad++; $display("FAIL held_first_status: got %0b want 110", {done_a, pass_a, fail_a}); end
    @(negedge clk);
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL held_restart_busy: got %0h want 1", busy_a); end
    total++; if ({done_a, pass_a, fail_a} !== 3'b000) begin bad++; $display("FAIL held_restart_clear: got %0b want 000", {done_a, pass_a, fail_a}); end
    total++; if ({we_a, addr_a} !== {1'b1, 11'd0}) begin bad++; $display("FAIL held_restart_first_op: got %0h want 800", {we_a, addr_a}); end
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    start_a    = 1'b0;
    start_b    = 1'b0;
    fault_mode = 0;
    test_reset();
    test_full_run();
    test_small_trace();
    test_stuck_at();
    test_coupling();
    test_reset_mid_run();
    test_start_ignored_and_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
